cpu_trace_monitor: RTL

Synthesizable, parametrised run monitor for the pipelined CPU, replacing console-only cycle counting and HALT/error reporting with on-chip hardware. It counts cycles, commits and per-stage stalls, and captures committed (PC, instruction) pairs into a circular trace buffer. It freezes a configurable number of cycles after a HALT or an opcode/function-code error. A post-mortem read port lets the bench or debug logic dump the captured history in oldest-first order.

---
 rtl/cpu_trace_monitor.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cpu_trace_monitor.sv
// Run monitor: cycle/commit/stall counters, circular commit trace,
// trigger-and-post-capture control and an oldest-first read port.
module cpu_trace_monitor #(
  parameter int ADDR_W    = 16,
  parameter int INSTR_W   = 16,
  parameter int STAGES    = 5,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 32,
  parameter int POST_TRIG = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      arm,
  input  logic                      commit_valid,
  input  logic [ADDR_W-1:0]         commit_pc,
  input  logic [INSTR_W-1:0]        commit_instr,
  input  logic [STAGES-1:0]         stall_vec,
  input  logic                      halt,
  input  logic                      opcode_err,
  input  logic                      funct_err,
  input  logic                      rd_en,
  input  logic [$clog2(DEPTH)-1:0]  rd_addr,
  output logic [1:0]                state,
  output logic                      done,
  output logic [1:0]                trig_cause,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [CNT_W-1:0]          commit_count,
  output logic [STAGES*CNT_W-1:0]   stall_count,
  output logic [$clog2(DEPTH):0]    trace_level,
  output logic                      rd_valid,
  output logic [ADDR_W-1:0]         rd_pc,
  output logic [INSTR_W-1:0]        rd_instr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = ADDR_W + INSTR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_POST = 2'b10,
    S_DONE = 2'b11
  } st_t;

  st_t                r_state;
  logic [CNT_W-1:0]   r_cyc;
  logic [CNT_W-1:0]   r_com;
  logic [CNT_W-1:0]   r_stall [STAGES];
  logic [AW-1:0]      r_wr_ptr;
  logic [LW-1:0]      r_level;
  logic [7:0]         r_post;
  logic [1:0]         r_cause;
  logic               r_rd_valid;
  logic [ADDR_W-1:0]  r_rd_pc;
  logic [INSTR_W-1:0] r_rd_instr;
  logic [EW-1:0]      r_mem [DEPTH];

  logic          w_active;
  logic          w_cap;
  logic          w_trig;
  logic          w_rd_ok;
  logic [AW-1:0] w_phys;
  logic [1:0]    w_cause;
  logic [EW-1:0] w_rd_word;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_active = (r_state == S_RUN) ||
                    (r_state == S_POST);
  assign w_cap    = w_active && commit_valid;
  assign w_trig   = halt | opcode_err | funct_err;

  // Logical index 0 is the oldest live entry.
  assign w_phys    = r_wr_ptr - r_level[AW-1:0] + rd_addr;
  assign w_rd_word = r_mem[w_phys];
  assign w_rd_ok   = rd_en && !w_active &&
                     ({1'b0, rd_addr} < r_level);

  always_comb begin
    w_cause = 2'b00;
    if (opcode_err)     w_cause = 2'b10;
    else if (funct_err) w_cause = 2'b11;
    else if (halt)      w_cause = 2'b01;
  end

  always_ff @(posedge clock) begin
    if (reset && w_cap)
      r_mem[r_wr_ptr] <= {commit_pc, commit_instr};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cyc      <= '0;
      r_com      <= '0;
      r_wr_ptr   <= '0;
      r_level    <= '0;
      r_post     <= '0;
      r_cause    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_pc    <= '0;
      r_rd_instr <= '0;
      for (int i = 0; i < STAGES; i++)
        r_stall[i] <= '0;
    end else begin
      r_rd_valid <= w_rd_ok;
      r_rd_pc    <= w_rd_ok ? w_rd_word[EW-1:INSTR_W] : '0;
      r_rd_instr <= w_rd_ok ? w_rd_word[INSTR_W-1:0] : '0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            r_state  <= S_RUN;
            r_cyc    <= '0;
            r_com    <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
            r_post   <= '0;
            r_cause  <= '0;
            for (int i = 0; i < STAGES; i++)
              r_stall[i] <= '0;
          end
        end
        S_RUN, S_POST: begin
          r_cyc <= sat_inc(r_cyc);
          for (int i = 0; i < STAGES; i++)
            if (stall_vec[i])
              r_stall[i] <= sat_inc(r_stall[i]);
          if (commit_valid) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_com    <= sat_inc(r_com);
            if (r_level != LW'(DEPTH))
              r_level <= r_level + LW'(1);
          end
          if (r_state == S_RUN && w_trig) begin
            r_cause <= w_cause;
            r_post  <= 8'(POST_TRIG);
            r_state <= (POST_TRIG == 0) ? S_DONE
                                        : S_POST;
          end else if (r_state == S_POST) begin
            r_post <= r_post - 8'd1;
            if (r_post == 8'd1)
              r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign state        = r_state;
  assign done         = (r_state == S_DONE);
  assign trig_cause   = r_cause;
  assign cycle_count  = r_cyc;
  assign commit_count = r_com;
  assign trace_level  = r_level;
  assign rd_valid     = r_rd_valid;
  assign rd_pc        = r_rd_pc;
  assign rd_instr     = r_rd_instr;

  always_comb begin
    stall_count = '0;
    for (int i = 0; i < STAGES; i++)
      stall_count[i*CNT_W +: CNT_W] = r_stall[i];
  end

endmodule
